// File: rtl/blackjack_auto_player.sv
// rtl/blackjack_auto_player.sv - self-play driver for the blackjack core
// Plays hit-below-threshold rounds and keeps saturating win/lose/tie/error tallies.
module blackjack_auto_player #(
  parameter int THRESH    = 17,
  parameter int ROUNDS    = 8,
  parameter int DEAL_WAIT = 2,
  parameter int HIT_WAIT  = 2,
  parameter int TIMEOUT   = 64,
  parameter int MAX_HITS  = 10
) (
  input  logic       clk,
  input  logic       res,
  input  logic       go,
  input  logic [4:0] p_c,
  input  logic [4:0] d_c,
  input  logic       win,
  input  logic       lose,
  input  logic       tie,
  output logic       start,
  output logic       hit,
  output logic       stand,
  output logic       busy,
  output logic       done,
  output logic [7:0] win_cnt,
  output logic [7:0] lose_cnt,
  output logic [7:0] tie_cnt,
  output logic [7:0] err_cnt,
  output logic [4:0] last_d_c
);

  localparam int WMAX_A = (TIMEOUT > DEAL_WAIT) ? TIMEOUT : DEAL_WAIT;
  localparam int WMAX   = (WMAX_A > HIT_WAIT) ? WMAX_A : HIT_WAIT;
  localparam int WW     = $clog2(WMAX + 1);
  localparam int HW     = $clog2(MAX_HITS + 1);

  localparam logic [WW-1:0] DEAL_LAST = WW'(DEAL_WAIT - 1);
  localparam logic [WW-1:0] HIT_LAST  = WW'(HIT_WAIT - 1);
  localparam logic [WW-1:0] TO_LAST   = WW'(TIMEOUT);
  localparam logic [HW-1:0] HIT_CAP   = HW'(MAX_HITS);
  localparam logic [4:0]    THR5      = 5'(THRESH);
  localparam logic [7:0]    RND_LAST  = 8'(ROUNDS - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_DEAL, S_DECIDE, S_HIT, S_HWAIT, S_STAND, S_RESULT, S_GAP, S_DONE
  } state_t;

  state_t        state, next_state;
  logic [WW-1:0] wcnt;
  logic [HW-1:0] hit_cnt;
  logic [7:0]    round_cnt;
  logic [1:0]    n_flags;
  logic          inc_win, inc_lose, inc_tie, inc_err;

  assign n_flags = {1'b0, win} + {1'b0, lose} + {1'b0, tie};

  always_comb begin
    next_state = state;
    inc_win    = 1'b0;
    inc_lose   = 1'b0;
    inc_tie    = 1'b0;
    inc_err    = 1'b0;
    case (state)
      S_IDLE, S_DONE: if (go) next_state = S_START;
      S_START:        next_state = S_DEAL;
      S_DEAL:         if (wcnt == DEAL_LAST) next_state = S_DECIDE;
      S_DECIDE: begin
        if (p_c > 5'd21 || p_c >= THR5 || hit_cnt == HIT_CAP) next_state = S_STAND;
        else next_state = S_HIT;
      end
      S_HIT:          next_state = S_HWAIT;
      S_HWAIT:        if (wcnt == HIT_LAST) next_state = S_DECIDE;
      S_STAND: begin
        // conflicting flags count only as an error, never toward the outcome tallies
        if (n_flags >= 2'd2) begin
          inc_err    = 1'b1;
          next_state = S_RESULT;
        end else if (n_flags == 2'd1) begin
          inc_win    = win;
          inc_lose   = lose;
          inc_tie    = tie;
          next_state = S_RESULT;
        end else if (wcnt == TO_LAST) begin
          inc_err    = 1'b1;
          next_state = S_RESULT;
        end
      end
      S_RESULT:       next_state = (round_cnt == RND_LAST) ? S_DONE : S_GAP;
      S_GAP:          next_state = S_START;
      default:        next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!res) begin
      state     <= S_IDLE;
      wcnt      <= '0;
      hit_cnt   <= '0;
      round_cnt <= '0;
      start     <= 1'b0;
      hit       <= 1'b0;
      stand     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      win_cnt   <= '0;
      lose_cnt  <= '0;
      tie_cnt   <= '0;
      err_cnt   <= '0;
      last_d_c  <= '0;
    end else begin
      state <= next_state;
      wcnt  <= (next_state != state) ? '0 : wcnt + WW'(1);
      // outputs decode the next state so they are registered yet aligned with it
      start <= (next_state == S_START);
      hit   <= (next_state == S_HIT);
      stand <= (next_state == S_STAND);
      busy  <= (next_state != S_IDLE) && (next_state != S_DONE);
      done  <= (next_state == S_DONE);

      if ((state == S_IDLE || state == S_DONE) && go) begin
        win_cnt   <= '0;
        lose_cnt  <= '0;
        tie_cnt   <= '0;
        err_cnt   <= '0;
        round_cnt <= '0;
      end
      if (state == S_HIT) hit_cnt <= hit_cnt + HW'(1);
      if (state == S_RESULT) begin
        last_d_c  <= d_c;
        hit_cnt   <= '0;
        round_cnt <= round_cnt + 8'd1;
      end
      if (inc_win  && win_cnt  != 8'hFF) win_cnt  <= win_cnt  + 8'd1;
      if (inc_lose && lose_cnt != 8'hFF) lose_cnt <= lose_cnt + 8'd1;
      if (inc_tie  && tie_cnt  != 8'hFF) tie_cnt  <= tie_cnt  + 8'd1;
      if (inc_err  && err_cnt  != 8'hFF) err_cnt  <= err_cnt  + 8'd1;
    end
  end

endmodule

// File: tb/tb_blackjack_auto_player.sv
// tb/tb_blackjack_auto_player.sv - directed bench for blackjack_auto_player
// Default parameters; a scripted game model feeds p_c updates after each hit.
module tb_blackjack_auto_player;

  logic       clk = 1'b0;
  logic       res, go, win, lose, tie;
  logic [4:0] p_c, d_c;
  logic       start, hit, stand, busy, done;
  logic [7:0] win_cnt, lose_cnt, tie_cnt, err_cnt;
  logic [4:0] last_d_c;

  int vecs = 0;
  int errs = 0;
  int cyc = 0;
  int nhits, last_hit, last_gap, n, cnt;
  logic [4:0] pc_seq [2];
  int seq_len = 0;
  int seq_idx = 0;
  logic [2:0] rs [8];

  blackjack_auto_player dut (
    .clk(clk), .res(res), .go(go), .p_c(p_c), .d_c(d_c),
    .win(win), .lose(lose), .tie(tie),
    .start(start), .hit(hit), .stand(stand), .busy(busy), .done(done),
    .win_cnt(win_cnt), .lose_cnt(lose_cnt), .tie_cnt(tie_cnt), .err_cnt(err_cnt),
    .last_d_c(last_d_c)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (hit === 1'b1) begin
      nhits++;
      if (last_hit >= 0) last_gap = cyc - last_hit;
      last_hit = cyc;
      if (seq_idx < seq_len) begin
        p_c = pc_seq[seq_idx];
        seq_idx++;
      end
    end
  endtask

  task automatic wait_stand(output int steps);
    steps    = 0;
    nhits    = 0;
    last_hit = -1;
    last_gap = 0;
    while (stand !== 1'b1 && steps < 300) begin
      step();
      steps++;
    end
    if (stand !== 1'b1) chk("stand_wait_expired", 32'(stand), 1);
  endtask

  task automatic apply(input logic w, input logic l, input logic t);
    win = w; lose = l; tie = t;
    step();
    win = 1'b0; lose = 1'b0; tie = 1'b0;
  endtask

  initial begin
    rs = '{3'b100, 3'b100, 3'b010, 3'b001, 3'b100, 3'b010, 3'b100, 3'b001};
    res = 1'b0; go = 1'b0; win = 1'b0; lose = 1'b0; tie = 1'b0;
    p_c = 5'd18; d_c = 5'd20;
    repeat (3) step();
    chk("rst_start", 32'(start), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_win_cnt", 32'(win_cnt), 0);
    chk("rst_last_d_c", 32'(last_d_c), 0);
    res = 1'b1;
    step();

    // round 1: p_c=18 stands at once, win three cycles into STAND
    go = 1'b1; step(); go = 1'b0;
    chk("go_start", 32'(start), 1);
    chk("go_busy", 32'(busy), 1);
    wait_stand(n);
    chk("first_decision_latency", n, 4);
    chk("r1_hits", nhits, 0);
    step(); step();
    apply(1'b1, 1'b0, 1'b0);
    chk("r1_win_cnt", 32'(win_cnt), 1);
    chk("r1_stand_low", 32'(stand), 0);
    chk("r1_lose_cnt", 32'(lose_cnt), 0);
    chk("r1_err_cnt", 32'(err_cnt), 0);
    step();
    chk("r1_last_d_c", 32'(last_d_c), 20);
    step();
    chk("r1_next_start", 32'(start), 1);

    // round 2: 10 -> 15 -> 19, two hits four cycles apart, then lose
    p_c = 5'd10;
    pc_seq[0] = 5'd15; pc_seq[1] = 5'd19; seq_idx = 0; seq_len = 2;
    wait_stand(n);
    chk("r2_hits", nhits, 2);
    chk("r2_hit_gap", last_gap, 4);
    apply(1'b0, 1'b1, 1'b0);
    chk("r2_lose_cnt", 32'(lose_cnt), 1);
    seq_len = 0;

    // round 3: bust total stands immediately; win+tie together is an error
    p_c = 5'd23;
    wait_stand(n);
    chk("r3_bust_hits", nhits, 0);
    apply(1'b1, 1'b0, 1'b1);
    chk("r3_err_cnt", 32'(err_cnt), 1);
    chk("r3_win_cnt", 32'(win_cnt), 1);
    chk("r3_tie_cnt", 32'(tie_cnt), 0);

    // round 4: stuck at 5 hits the cap, then times out
    p_c = 5'd5;
    wait_stand(n);
    chk("r4_hit_cap", nhits, 10);
    cnt = 1;
    while (stand === 1'b1 && cnt < 100) begin
      step();
      if (stand === 1'b1) cnt++;
    end
    chk("r4_stand_cycles", cnt, 65);
    chk("r4_err_cnt", 32'(err_cnt), 2);

    // round 5: reset while standing
    p_c = 5'd18;
    wait_stand(n);
    res = 1'b0; step(); res = 1'b1;
    chk("midrst_stand", 32'(stand), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_err_cnt", 32'(err_cnt), 0);
    chk("midrst_lose_cnt", 32'(lose_cnt), 0);

    // full eight-round session with a go pulse while busy
    go = 1'b1; step(); go = 1'b0;
    chk("sess_start", 32'(start), 1);
    for (int i = 0; i < 8; i++) begin
      if (i == 2) go = 1'b1;
      wait_stand(n);
      go = 1'b0;
      d_c = 5'(i + 3);
      apply(rs[i][2], rs[i][1], rs[i][0]);
    end
    chk("sess_result_done", 32'(done), 0);
    step();
    chk("sess_done", 32'(done), 1);
    chk("sess_busy", 32'(busy), 0);
    chk("sess_win_cnt", 32'(win_cnt), 4);
    chk("sess_lose_cnt", 32'(lose_cnt), 2);
    chk("sess_tie_cnt", 32'(tie_cnt), 2);
    chk("sess_err_cnt", 32'(err_cnt), 0);
    chk("sess_last_d_c", 32'(last_d_c), 10);
    repeat (3) step();
    chk("done_hold_win", 32'(win_cnt), 4);

    // go from DONE restarts with cleared tallies
    go = 1'b1; step(); go = 1'b0;
    chk("restart_start", 32'(start), 1);
    chk("restart_busy", 32'(busy), 1);
    chk("restart_done", 32'(done), 0);
    chk("restart_win_cnt", 32'(win_cnt), 0);
    chk("restart_tie_cnt", 32'(tie_cnt), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
